// File: rtl/input_conditioner.sv
// Button front end: synchronises and debounces right/left/fire, emits per-frame
// move strobes and a single cooldown-gated shot request for the game core.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES      = 1250000,
  parameter int FIRE_COOLDOWN_CYCLES = 12500000,
  parameter int CNT_W                = 24
) (
  input  logic clk125,
  input  logic rst,
  input  logic right,
  input  logic left,
  input  logic fire,
  input  logic frame_tick,
  input  logic bullet_busy,
  output logic btn_right_db,
  output logic btn_left_db,
  output logic move_right_step,
  output logic move_left_step,
  output logic fire_pulse,
  output logic fire_ready
);

  localparam int BTN_R = 0;
  localparam int BTN_L = 1;
  localparam int BTN_F = 2;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(FIRE_COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    COOLDOWN     = 2'd1,
    WAIT_RELEASE = 2'd2
  } fire_state_e;

  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       db_q, db_d;
  logic [CNT_W-1:0] db_cnt_q [3];
  logic [CNT_W-1:0] db_cnt_d [3];
  logic             fire_prev_q;
  fire_state_e      state_q, state_d;
  logic [CNT_W-1:0] cd_cnt_q, cd_cnt_d;
  logic             move_r_q, move_r_d;
  logic             move_l_q, move_l_d;
  logic             fire_pulse_q, fire_pulse_d;
  logic             fire_ready_q, fire_ready_d;
  logic             fire_rise_s;

  // Debounce: a new synchronised level is accepted only after it has held for
  // DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] == db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_d[i] = sync2_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign fire_rise_s = db_q[BTN_F] & ~fire_prev_q;

  // Fire FSM next state; ready looks at the next state so it drops with the pulse.
  always_comb begin
    state_d      = state_q;
    cd_cnt_d     = cd_cnt_q;
    fire_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (fire_rise_s && !bullet_busy) begin
          fire_pulse_d = 1'b1;
          state_d      = COOLDOWN;
          cd_cnt_d     = '0;
        end else if (fire_rise_s) begin
          state_d = WAIT_RELEASE;
        end else begin
          state_d = IDLE;
        end
      end
      COOLDOWN: begin
        if (cd_cnt_q == CD_LAST) begin
          state_d = db_q[BTN_F] ? WAIT_RELEASE : IDLE;
        end else begin
          cd_cnt_d = cd_cnt_q + CNT_W'(1);
        end
      end
      WAIT_RELEASE: begin
        if (!db_q[BTN_F]) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_RELEASE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    fire_ready_d = (state_d == IDLE) & ~bullet_busy;
    move_r_d     = frame_tick & db_q[BTN_R] & ~db_q[BTN_L];
    move_l_d     = frame_tick & db_q[BTN_L] & ~db_q[BTN_R];
  end

  // State and output registers.
  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) begin
      sync1_q      <= 3'b000;
      sync2_q      <= 3'b000;
      db_q         <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
      fire_prev_q  <= 1'b0;
      state_q      <= IDLE;
      cd_cnt_q     <= '0;
      move_r_q     <= 1'b0;
      move_l_q     <= 1'b0;
      fire_pulse_q <= 1'b0;
      fire_ready_q <= 1'b1;
    end else begin
      sync1_q      <= {fire, left, right};
      sync2_q      <= sync1_q;
      db_q         <= db_d;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      fire_prev_q  <= db_q[BTN_F];
      state_q      <= state_d;
      cd_cnt_q     <= cd_cnt_d;
      move_r_q     <= move_r_d;
      move_l_q     <= move_l_d;
      fire_pulse_q <= fire_pulse_d;
      fire_ready_q <= fire_ready_d;
    end
  end

  assign btn_right_db    = db_q[BTN_R];
  assign btn_left_db     = db_q[BTN_L];
  assign move_right_step = move_r_q;
  assign move_left_step  = move_l_q;
  assign fire_pulse      = fire_pulse_q;
  assign fire_ready      = fire_ready_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random button activity,
// every cycle compared against a behavioural model of the button rules.
module tb_input_conditioner;

  localparam int D = 4;
  localparam int C = 8;

  logic clk125 = 1'b0;
  logic rst, right, left, fire, frame_tick, bullet_busy;
  logic btn_right_db, btn_left_db, move_right_step, move_left_step;
  logic fire_pulse, fire_ready;

  int vectors = 0;
  int miscompares = 0;
  int n_fp = 0;
  int n_mr = 0;
  int n_ml = 0;
  int base;

  // Model state: raw samples in flight, accepted levels, stability runs,
  // remaining cooldown and whether a release is still owed.
  logic [2:0] m_seen1, m_seen2, m_db;
  int         m_run [3];
  logic       m_prev_fire;
  int         m_cool;
  logic       m_wait;
  logic       m_mr, m_ml, m_fp, m_fr;

  always #4 clk125 = ~clk125;

  input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .FIRE_COOLDOWN_CYCLES(C),
    .CNT_W(8)
  ) dut (
    .clk125(clk125),
    .rst(rst),
    .right(right),
    .left(left),
    .fire(fire),
    .frame_tick(frame_tick),
    .bullet_busy(bullet_busy),
    .btn_right_db(btn_right_db),
    .btn_left_db(btn_left_db),
    .move_right_step(move_right_step),
    .move_left_step(move_left_step),
    .fire_pulse(fire_pulse),
    .fire_ready(fire_ready)
  );

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_seen1 = 3'b000;
    m_seen2 = 3'b000;
    m_db = 3'b000;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    m_prev_fire = 1'b0;
    m_cool = 0;
    m_wait = 1'b0;
    m_mr = 1'b0;
    m_ml = 1'b0;
    m_fp = 1'b0;
    m_fr = 1'b1;
  endtask

  task automatic model_step();
    logic [2:0] old_db;
    logic rise;
    if (rst) begin
      model_reset();
      return;
    end
    old_db = m_db;
    rise = old_db[2] && !m_prev_fire;
    m_fp = 1'b0;
    if (m_cool > 0) begin
      m_cool--;
      if (m_cool == 0 && old_db[2]) m_wait = 1'b1;
    end else if (m_wait) begin
      if (!old_db[2]) m_wait = 1'b0;
    end else if (rise) begin
      if (bullet_busy) m_wait = 1'b1;
      else begin
        m_fp = 1'b1;
        m_cool = C;
      end
    end
    m_fr = (m_cool == 0) && !m_wait && !bullet_busy;
    m_mr = frame_tick && old_db[0] && !old_db[1];
    m_ml = frame_tick && old_db[1] && !old_db[0];
    m_prev_fire = old_db[2];
    for (int i = 0; i < 3; i++) begin
      if (m_seen2[i] != old_db[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_db[i] = m_seen2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_seen2 = m_seen1;
    m_seen1 = {fire, left, right};
  endtask

  function automatic logic [7:0] dut_vec();
    return {2'b00, btn_right_db, btn_left_db, move_right_step, move_left_step, fire_pulse, fire_ready};
  endfunction

  function automatic logic [7:0] exp_vec();
    return {2'b00, m_db[0], m_db[1], m_mr, m_ml, m_fp, m_fr};
  endfunction

  task automatic tick(input string tag);
    @(posedge clk125);
    model_step();
    @(negedge clk125);
    check_eq(tag, dut_vec(), exp_vec());
    check_eq("ready_pulse_excl", {7'd0, fire_pulse & fire_ready}, 8'd0);
    n_fp += int'(fire_pulse);
    n_mr += int'(move_right_step);
    n_ml += int'(move_left_step);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int k = 0; k < n; k++) tick(tag);
  endtask

  task automatic frame(input string tag);
    frame_tick = 1'b1;
    tick(tag);
    frame_tick = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    right = 1'b0;
    left = 1'b0;
    fire = 1'b0;
    frame_tick = 1'b0;
    bullet_busy = 1'b0;
    model_reset();
    #2 rst = 1'b1;
    @(negedge clk125);
    #1 check_eq("reset_state", dut_vec(), 8'h01);
    ticks(2, "reset");
    rst = 1'b0;
    ticks(3, "idle");

    // Glitch shorter than the debounce window.
    base = n_mr;
    right = 1'b1;
    ticks(3, "s1_glitch");
    right = 1'b0;
    for (int f = 0; f < 10; f++) begin
      frame("s1_frame");
      ticks(4, "s1");
    end
    check_eq("s1_no_step", 8'(n_mr - base), 8'd0);

    // Clean right press, then left joins.
    right = 1'b1;
    ticks(5, "s2");
    check_eq("s2_db_edge5", {7'd0, btn_right_db}, 8'd0);
    tick("s2");
    check_eq("s2_db_edge6", {7'd0, btn_right_db}, 8'd1);
    base = n_mr;
    for (int f = 0; f < 3; f++) begin
      frame("s2_frame");
      check_eq("s2_step", {7'd0, move_right_step}, 8'd1);
      ticks(9, "s2");
    end
    check_eq("s2_step_count", 8'(n_mr - base), 8'd3);
    left = 1'b1;
    ticks(7, "s2_left");
    base = n_mr + n_ml;
    for (int f = 0; f < 3; f++) begin
      frame("s2_both");
      ticks(5, "s2_both");
    end
    check_eq("s2_both_none", 8'(n_mr + n_ml - base), 8'd0);
    right = 1'b0;
    left = 1'b0;
    ticks(10, "s2_rel");

    // Held fire gives exactly one pulse on edge 7, then a re-press.
    base = n_fp;
    fire = 1'b1;
    ticks(6, "s3");
    check_eq("s3_edge6", {7'd0, fire_pulse}, 8'd0);
    tick("s3");
    check_eq("s3_edge7", {7'd0, fire_pulse}, 8'd1);
    ticks(52, "s3_hold");
    check_eq("s3_one_pulse", 8'(n_fp - base), 8'd1);
    check_eq("s3_ready_held", {7'd0, fire_ready}, 8'd0);
    fire = 1'b0;
    ticks(8, "s3_rel");
    check_eq("s3_ready_back", {7'd0, fire_ready}, 8'd1);
    fire = 1'b1;
    ticks(10, "s3_again");
    fire = 1'b0;
    ticks(20, "s3_rel2");
    check_eq("s3_two_pulses", 8'(n_fp - base), 8'd2);

    // Second tap lands inside cooldown.
    base = n_fp;
    fire = 1'b1;
    ticks(4, "s4_tap1");
    fire = 1'b0;
    ticks(4, "s4_gap");
    fire = 1'b1;
    ticks(10, "s4_tap2");
    fire = 1'b0;
    ticks(20, "s4_rel");
    check_eq("s4_one_pulse", 8'(n_fp - base), 8'd1);

    // Bullet in flight drops the press.
    base = n_fp;
    bullet_busy = 1'b1;
    tick("s5_busy");
    check_eq("s5_ready_busy", {7'd0, fire_ready}, 8'd0);
    fire = 1'b1;
    ticks(12, "s5_press");
    check_eq("s5_dropped", 8'(n_fp - base), 8'd0);
    fire = 1'b0;
    ticks(8, "s5_rel");
    bullet_busy = 1'b0;
    ticks(2, "s5_clear");
    fire = 1'b1;
    ticks(10, "s5_press2");
    fire = 1'b0;
    ticks(20, "s5_rel2");
    check_eq("s5_one_pulse", 8'(n_fp - base), 8'd1);

    // Reset in cooldown with fire held.
    fire = 1'b1;
    ticks(10, "s6_pre");
    rst = 1'b1;
    #1 check_eq("s6_async_clear", dut_vec(), 8'h01);
    ticks(2, "s6_rst");
    rst = 1'b0;
    ticks(6, "s6_post");
    check_eq("s6_edge6", {7'd0, fire_pulse}, 8'd0);
    tick("s6_post");
    check_eq("s6_edge7", {7'd0, fire_pulse}, 8'd1);
    fire = 1'b0;
    ticks(20, "s6_rel");

    // Random button, frame, busy and reset activity.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) right = ~right;
      if ($urandom_range(0, 5) == 0) left = ~left;
      if ($urandom_range(0, 5) == 0) fire = ~fire;
      frame_tick = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 40) == 0) bullet_busy = ~bullet_busy;
      rst = ($urandom_range(0, 599) == 0);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
